// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - state encoding, ALU_CTRL codes and op-class helpers for alu_mc_seq
package alu_mc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] ALU_CTRL_ADD    = 32'd0;
  localparam logic [31:0] ALU_CTRL_SUB    = 32'd1;
  localparam logic [31:0] ALU_CTRL_AND    = 32'd2;
  localparam logic [31:0] ALU_CTRL_OR     = 32'd3;
  localparam logic [31:0] ALU_CTRL_XOR    = 32'd4;
  localparam logic [31:0] ALU_CTRL_SLL    = 32'd5;
  localparam logic [31:0] ALU_CTRL_SRL    = 32'd6;
  localparam logic [31:0] ALU_CTRL_SRA    = 32'd7;
  localparam logic [31:0] ALU_CTRL_SLT    = 32'd8;
  localparam logic [31:0] ALU_CTRL_SLTU   = 32'd9;
  localparam logic [31:0] ALU_CTRL_MUL    = 32'd10;
  localparam logic [31:0] ALU_CTRL_MULH   = 32'd11;
  localparam logic [31:0] ALU_CTRL_MULHSU = 32'd12;
  localparam logic [31:0] ALU_CTRL_MULHU  = 32'd13;
  localparam logic [31:0] ALU_CTRL_DIV    = 32'd14;
  localparam logic [31:0] ALU_CTRL_DIVU   = 32'd15;
  localparam logic [31:0] ALU_CTRL_REM    = 32'd16;
  localparam logic [31:0] ALU_CTRL_REMU   = 32'd17;

  function automatic logic is_mul(input logic [31:0] ctrl);
    return (ctrl >= ALU_CTRL_MUL) && (ctrl <= ALU_CTRL_MULHU);
  endfunction

  function automatic logic is_div(input logic [31:0] ctrl);
    return (ctrl >= ALU_CTRL_DIV) && (ctrl <= ALU_CTRL_REMU);
  endfunction

  function automatic logic is_rem(input logic [31:0] ctrl);
    return (ctrl == ALU_CTRL_REM) || (ctrl == ALU_CTRL_REMU);
  endfunction

  // Encodings are contiguous, so anything past REMU is illegal
  function automatic logic is_legal(input logic [31:0] ctrl);
    return ctrl <= ALU_CTRL_REMU;
  endfunction

endpackage

// File: rtl/alu_mc_seq_divider.sv
// rtl/alu_mc_seq_divider.sv - XLEN-parametrised unsigned restoring divider, one quotient bit per cycle
module seq_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dsr;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;
  logic            ge;

  // Trial subtraction: a borrow out of bit XLEN means the divisor did not fit
  always_comb begin
    trial     = {rem, quo[XLEN-1]};
    diff      = trial - {1'b0, dsr};
    ge        = ~diff[XLEN];
    quotient  = {quo[XLEN-2:0], ge};
    remainder = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
    done      = busy && (cnt == LAST);
  end

  // Iteration registers; quotient/remainder outputs are the post-step values, valid while done
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dsr  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      quo  <= dividend;
      rem  <= '0;
      dsr  <= divisor;
    end else if (busy) begin
      quo <= quotient;
      rem <= remainder;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc_seq.sv
// rtl/alu_mc_seq.sv - multi-cycle ALU: single-cycle simple ops, iterative MUL/DIV behind valid/ready
module alu_mc_seq
  import alu_mc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ctrl,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            err
);

  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  state_t            state, state_nxt;
  logic [31:0]       ctrl_q;
  logic [SHW-1:0]    cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mcand;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   res_q;
  logic              err_q;

  logic              accept;
  logic              s1, s2, a_neg, b_neg;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN-1:0]   simple_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN-1:0]   mul_res, div_res, q_s, r_s;
  logic              dv_start, dv_busy, dv_done;
  logic [XLEN-1:0]   dv_quo, dv_rem;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign res       = res_q;
  assign err       = err_q;
  assign dv_start  = accept && is_div(ctrl) && (op2 != '0);

  // Operand signedness and magnitudes; MULHSU keeps op2 unsigned
  always_comb begin
    s1    = (ctrl == ALU_CTRL_MUL) || (ctrl == ALU_CTRL_MULH) || (ctrl == ALU_CTRL_MULHSU) ||
            (ctrl == ALU_CTRL_DIV) || (ctrl == ALU_CTRL_REM);
    s2    = (ctrl == ALU_CTRL_MUL) || (ctrl == ALU_CTRL_MULH) ||
            (ctrl == ALU_CTRL_DIV) || (ctrl == ALU_CTRL_REM);
    a_neg = s1 && op1[XLEN-1];
    b_neg = s2 && op2[XLEN-1];
    mag1  = a_neg ? -op1 : op1;
    mag2  = b_neg ? -op2 : op2;
  end

  // Single-cycle operations, evaluated on the request inputs
  always_comb begin
    simple_res = '0;
    case (ctrl)
      ALU_CTRL_ADD:  simple_res = op1 + op2;
      ALU_CTRL_SUB:  simple_res = op1 - op2;
      ALU_CTRL_AND:  simple_res = op1 & op2;
      ALU_CTRL_OR:   simple_res = op1 | op2;
      ALU_CTRL_XOR:  simple_res = op1 ^ op2;
      ALU_CTRL_SLL:  simple_res = op1 << op2[SHW-1:0];
      ALU_CTRL_SRL:  simple_res = op1 >> op2[SHW-1:0];
      ALU_CTRL_SRA:  simple_res = $signed(op1) >>> op2[SHW-1:0];
      ALU_CTRL_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_CTRL_SLTU: simple_res = {{(XLEN-1){1'b0}}, op1 < op2};
      default:       simple_res = '0;
    endcase
  end

  // Shift-add step: low half of acc holds the remaining multiplier bits, high half the partial sum
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {mul_sum, acc[XLEN-1:1]};
    prod    = neg_q ? -acc_nxt : acc_nxt;
    mul_res = (ctrl_q == ALU_CTRL_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    q_s     = neg_q ? -dv_quo : dv_quo;
    r_s     = neg_r ? -dv_rem : dv_rem;
    div_res = is_rem(ctrl_q) ? r_s : q_s;
  end

  seq_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (dv_start),
    .dividend  (mag1),
    .divisor   (mag2),
    .busy      (dv_busy),
    .done      (dv_done),
    .quotient  (dv_quo),
    .remainder (dv_rem)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!is_legal(ctrl))                  state_nxt = S_DONE;
          else if (is_mul(ctrl))                state_nxt = S_MUL;
          else if (is_div(ctrl) && op2 != '0)   state_nxt = S_DIV;
          else                                  state_nxt = S_DONE;
        end
      end
      S_MUL:  if (cnt == LAST) state_nxt = S_DONE;
      S_DIV: begin
        if (dv_done)       state_nxt = S_DONE;
        else if (!dv_busy) state_nxt = S_IDLE;
      end
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the request, iterate, register the final result
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          ctrl_q <= ctrl;
          cnt    <= '0;
          err_q  <= 1'b0;
          if (!is_legal(ctrl)) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else if (is_mul(ctrl)) begin
            acc   <= {{XLEN{1'b0}}, mag2};
            mcand <= mag1;
            neg_q <= a_neg ^ b_neg;
          end else if (is_div(ctrl)) begin
            if (op2 == '0) begin
              res_q <= is_rem(ctrl) ? op1 : '1;
            end else begin
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end else begin
            res_q <= simple_res;
          end
        end
        S_MUL: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) res_q <= mul_res;
        end
        S_DIV: begin
          cnt <= cnt + 1'b1;
          if (dv_done) res_q <= div_res;
        end
        default: ;
      endcase
    end
  end

endmodule
